muldiv_hilo_ctrl: RTL

//   EX-stage issue/writeback controller for MULT/MULTU/DIV/DIVU/MTHI/MTLO. Owns the HI/LO

---
 rtl/muldiv_hilo_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/muldiv_hilo_ctrl.sv
// HI/LO owner for the EX stage: runs multiplies in two cycles, sequences the external
// iterative Divider through start/busy, and stalls the pipeline until HI/LO are written.
module muldiv_hilo_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_op_valid,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_rs_data,
  input  logic [31:0] i_rt_data,
  input  logic        i_flush,
  output logic        o_stall,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_div_start,
  output logic [31:0] o_div_dividend,
  output logic [31:0] o_div_divisor,
  output logic        o_div_is_unsigned,
  input  logic [31:0] i_div_quotient,
  input  logic [31:0] i_div_remainder,
  input  logic        i_div_busy
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_CALC,
    S_MUL_WB,
    S_DIV_DRAIN,
    S_DIV_START,
    S_DIV_WAIT
  } state_t;

  state_t      state_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] rs_q, rt_q;
  logic        uns_q;
  logic [63:0] prod_q;

  logic        is_mul, is_div, accept, completing;
  logic [63:0] mul_a, mul_b, mul_p;

  assign is_mul = (i_op == OP_MULT) || (i_op == OP_MULTU);
  assign is_div = (i_op == OP_DIV)  || (i_op == OP_DIVU);
  assign accept = (state_q == S_IDLE) && i_op_valid && !i_flush && (is_mul || is_div);

  assign completing = (state_q == S_MUL_WB) || ((state_q == S_DIV_WAIT) && !i_div_busy);

  assign o_stall = !i_flush && (((state_q != S_IDLE) && !completing) || accept);

  // Extending to 64 bits and keeping the low half gives the exact 33x33 signed/unsigned product.
  assign mul_a = {{32{!uns_q && rs_q[31]}}, rs_q};
  assign mul_b = {{32{!uns_q && rt_q[31]}}, rt_q};
  assign mul_p = mul_a * mul_b;

  assign o_hi              = hi_q;
  assign o_lo              = lo_q;
  assign o_div_dividend    = rs_q;
  assign o_div_divisor     = rt_q;
  assign o_div_is_unsigned = uns_q;
  assign o_div_start       = (state_q == S_DIV_START) && !i_flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      uns_q   <= 1'b0;
      prod_q  <= '0;
    end else if (i_flush) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_op_valid) begin
            if (is_mul || is_div) begin
              rs_q  <= i_rs_data;
              rt_q  <= i_rt_data;
              uns_q <= (i_op == OP_MULTU) || (i_op == OP_DIVU);
            end
            if (is_mul)
              state_q <= S_MUL_CALC;
            else if (is_div)
              state_q <= i_div_busy ? S_DIV_DRAIN : S_DIV_START;
            else if (i_op == OP_MTHI)
              hi_q <= i_rs_data;
            else if (i_op == OP_MTLO)
              lo_q <= i_rs_data;
          end
        end
        S_MUL_CALC: begin
          prod_q  <= mul_p;
          state_q <= S_MUL_WB;
        end
        S_MUL_WB: begin
          hi_q    <= prod_q[63:32];
          lo_q    <= prod_q[31:0];
          state_q <= S_IDLE;
        end
        // A flushed divide may still be running; it must finish before a new start.
        S_DIV_DRAIN: begin
          if (!i_div_busy)
            state_q <= S_DIV_START;
        end
        S_DIV_START: begin
          state_q <= S_DIV_WAIT;
        end
        S_DIV_WAIT: begin
          if (!i_div_busy) begin
            lo_q    <= i_div_quotient;
            hi_q    <= i_div_remainder;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
